// File: rtl/alu_src_pkg.sv
// Shared constants for the ALU operand-select stage: source indices,
// skid-buffer state encoding and the select-width helper.
package alu_src_pkg;

   localparam int unsigned SRC_RS    = 0;
   localparam int unsigned SRC_SHAMT = 1;
   localparam int unsigned SRC_PC    = 2;
   localparam int unsigned SRC_FWD   = 3;

   typedef logic [1:0] state_t;
   localparam state_t EMPTY = 2'b00;
   localparam state_t FULL1 = 2'b01;
   localparam state_t FULL2 = 2'b10;

   // A single source still needs a 1-bit select field.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/operand_sel_stage_if.sv
// Bundle of the operand-select stage handshake and data signals.
interface operand_sel_stage_if
   import alu_src_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NSRC  = 4,
   localparam int unsigned SELW = sel_width(NSRC)
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [SELW-1:0]       sel_a;
   logic [SELW-1:0]       sel_b;
   logic [NSRC*WIDTH-1:0] src;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      op_a;
   logic [WIDTH-1:0]      op_b;
   logic                  sel_err;

   modport master (
      output in_valid, sel_a, sel_b, src, flush, out_ready,
      input  in_ready, out_valid, op_a, op_b, sel_err
   );

   modport slave (
      input  in_valid, sel_a, sel_b, src, flush, out_ready,
      output in_ready, out_valid, op_a, op_b, sel_err
   );

endinterface

// File: rtl/operand_sel.sv
// Combinational NSRC:1 operand selector; out-of-range selects yield zero
// and raise err.
module operand_sel #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NSRC  = 4,
   parameter int unsigned SELW  = 2
) (
   input  logic [SELW-1:0]       sel,
   input  logic [NSRC*WIDTH-1:0] src,
   output logic [WIDTH-1:0]      op,
   output logic                  err
);

   always_comb begin
      op  = '0;
      err = (32'(sel) >= NSRC);
      for (int unsigned k = 0; k < NSRC; k++) begin
         if (32'(sel) == k) op = src[k*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/operand_sel_stage.sv
// Operand-select pipeline stage: picks A/B operands from NSRC sources at
// input acceptance and holds them in a two-entry skid buffer.
module operand_sel_stage
   import alu_src_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NSRC  = 4,
   localparam int unsigned SELW = sel_width(NSRC)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SELW-1:0]       sel_a,
   input  logic [SELW-1:0]       sel_b,
   input  logic [NSRC*WIDTH-1:0] src,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      op_a,
   output logic [WIDTH-1:0]      op_b,
   output logic                  sel_err
);

   logic [WIDTH-1:0] pick_a, pick_b;
   logic [WIDTH-1:0] skid_a, skid_b;
   logic             err_a, err_b;
   logic             accept, xfer;
   logic             load_main, load_skid, move_skid;
   state_t           state, state_nxt;

   operand_sel #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) u_sel_a (
      .sel(sel_a), .src(src), .op(pick_a), .err(err_a)
   );

   operand_sel #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) u_sel_b (
      .sel(sel_b), .src(src), .op(pick_b), .err(err_b)
   );

   assign accept = in_valid & in_ready;
   assign xfer   = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               load_main = 1'b1;
               state_nxt = FULL1;
            end
         end
         FULL1: begin
            if (accept && xfer) begin
               load_main = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_nxt = FULL2;
            end else if (xfer) begin
               state_nxt = EMPTY;
            end
         end
         FULL2: begin
            if (xfer) begin
               move_skid = 1'b1;
               state_nxt = FULL1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // Flush overrides every event and drops any same-cycle request.
      if (flush) begin
         state_nxt = EMPTY;
         load_main = 1'b0;
         load_skid = 1'b0;
         move_skid = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         op_a      <= '0;
         op_b      <= '0;
         skid_a    <= '0;
         skid_b    <= '0;
         sel_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         out_valid <= (state_nxt != EMPTY);
         in_ready  <= (state_nxt != FULL2);
         if (load_main) begin
            op_a <= pick_a;
            op_b <= pick_b;
         end else if (move_skid) begin
            op_a <= skid_a;
            op_b <= skid_b;
         end
         if (load_skid) begin
            skid_a <= pick_a;
            skid_b <= pick_b;
         end
         if (accept && !flush && (err_a || err_b)) sel_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_operand_sel_stage.sv
// Bench for operand_sel_stage (NSRC=3): directed table, streaming, async
// reset, then randomized traffic against a queue-based reference model.
module tb_operand_sel_stage;
   import alu_src_pkg::*;

   localparam int unsigned W = 32;
   localparam int unsigned N = 3;
   localparam logic [W-1:0] S0 = 32'h1234_5678;
   localparam logic [W-1:0] S1 = 32'hCAFE_F00D;
   localparam logic [W-1:0] S2 = 32'h0000_0040;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   operand_sel_stage_if #(.WIDTH(W), .NSRC(N)) bus ();

   operand_sel_stage #(.WIDTH(W), .NSRC(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(bus.in_valid), .in_ready(bus.in_ready),
      .sel_a(bus.sel_a), .sel_b(bus.sel_b), .src(bus.src),
      .flush(bus.flush),
      .out_valid(bus.out_valid), .out_ready(bus.out_ready),
      .op_a(bus.op_a), .op_b(bus.op_b), .sel_err(bus.sel_err)
   );

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   typedef struct packed {
      logic         iv;
      logic [1:0]   sa;
      logic [1:0]   sb;
      logic         ordy;
      logic         fl;
      logic         e_ov;
      logic         e_ir;
      logic [W-1:0] e_a;
      logic [W-1:0] e_b;
      logic         e_err;
   } vec_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } pair_t;

   pair_t mq[$];
   logic  m_err;
   vec_t  tbl[15];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic vec_t row(input logic iv, input logic [1:0] sa, input logic [1:0] sb,
                                input logic ordy, input logic fl, input logic e_ov,
                                input logic e_ir, input logic [W-1:0] e_a,
                                input logic [W-1:0] e_b, input logic e_err);
      return '{iv, sa, sb, ordy, fl, e_ov, e_ir, e_a, e_b, e_err};
   endfunction

   function automatic logic [W-1:0] word(input logic [1:0] s, input logic [N*W-1:0] v);
      int unsigned k;
      k = 32'(s);
      return (k < N) ? v[k*W +: W] : '0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: a FIFO of at most two operand pairs; pop on output transfer,
   // push when fewer than two were held before the edge.
   task automatic tick_model();
      bit    pop, push, bad, fl;
      pair_t p;
      pop  = (mq.size() > 0) && bus.out_ready;
      push = bus.in_valid && (mq.size() < 2);
      fl   = bus.flush;
      p.a  = word(bus.sel_a, bus.src);
      p.b  = word(bus.sel_b, bus.src);
      bad  = (32'(bus.sel_a) >= N) || (32'(bus.sel_b) >= N);
      step();
      if (fl) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) begin
            mq.push_back(p);
            if (bad) m_err = 1'b1;
         end
      end
      chk("rnd_out_valid", W'(bus.out_valid), W'(mq.size() > 0));
      chk("rnd_in_ready", W'(bus.in_ready), W'(mq.size() < 2));
      chk("rnd_sel_err", W'(bus.sel_err), W'(m_err));
      if (mq.size() > 0) begin
         chk("rnd_op_a", bus.op_a, mq[0].a);
         chk("rnd_op_b", bus.op_b, mq[0].b);
      end
   endtask

   initial begin
      logic [W-1:0] ea, eb, hold_a;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.sel_a     = '0;
      bus.sel_b     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      bus.src       = {S2, S1, S0};

      repeat (3) step();
      chk("rst_out_valid", W'(bus.out_valid), '0);
      chk("rst_in_ready", W'(bus.in_ready), W'(1));
      chk("rst_op_a", bus.op_a, '0);
      chk("rst_op_b", bus.op_b, '0);
      chk("rst_sel_err", W'(bus.sel_err), '0);
      rst_n = 1'b1;

      // single request, backpressure/skid, flush in FULL2, out-of-range select
      tbl[0]  = row(1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, S2, S0, 1'b0);
      tbl[1]  = row(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
      tbl[2]  = row(1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, S0, S1, 1'b0);
      tbl[3]  = row(1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, S0, S1, 1'b0);
      tbl[4]  = row(1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, S0, S1, 1'b0);
      tbl[5]  = row(1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, S1, S2, 1'b0);
      tbl[6]  = row(1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, S2, S2, 1'b0);
      tbl[7]  = row(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
      tbl[8]  = row(1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, S1, S0, 1'b0);
      tbl[9]  = row(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, S1, S0, 1'b0);
      tbl[10] = row(1'b1, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
      tbl[11] = row(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
      tbl[12] = row(1'b1, 2'd3, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, '0, S1, 1'b1);
      tbl[13] = row(1'b1, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, S0, S2, 1'b1);
      tbl[14] = row(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 1'b1);

      for (int i = 0; i < 15; i++) begin
         bus.in_valid  = tbl[i].iv;
         bus.sel_a     = tbl[i].sa;
         bus.sel_b     = tbl[i].sb;
         bus.out_ready = tbl[i].ordy;
         bus.flush     = tbl[i].fl;
         step();
         chk($sformatf("tbl%0d_out_valid", i), W'(bus.out_valid), W'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_in_ready", i), W'(bus.in_ready), W'(tbl[i].e_ir));
         chk($sformatf("tbl%0d_sel_err", i), W'(bus.sel_err), W'(tbl[i].e_err));
         if (tbl[i].e_ov) begin
            chk($sformatf("tbl%0d_op_a", i), bus.op_a, tbl[i].e_a);
            chk($sformatf("tbl%0d_op_b", i), bus.op_b, tbl[i].e_b);
         end
      end
      bus.flush = 1'b0;

      // eight back-to-back requests, each visible the cycle after acceptance
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.src      = {$urandom(), $urandom(), $urandom()};
         bus.in_valid = 1'b1;
         bus.sel_a    = 2'(i % 3);
         bus.sel_b    = 2'((i + 2) % 3);
         ea = word(bus.sel_a, bus.src);
         eb = word(bus.sel_b, bus.src);
         step();
         chk($sformatf("stream%0d_out_valid", i), W'(bus.out_valid), W'(1));
         chk($sformatf("stream%0d_in_ready", i), W'(bus.in_ready), W'(1));
         chk($sformatf("stream%0d_op_a", i), bus.op_a, ea);
         chk($sformatf("stream%0d_op_b", i), bus.op_b, eb);
      end
      bus.in_valid = 1'b0;
      step();
      chk("stream_drain_out_valid", W'(bus.out_valid), '0);

      // fill to FULL2, then async reset between edges
      bus.src       = {S2, S1, S0};
      bus.in_valid  = 1'b1;
      bus.sel_a     = 2'd0;
      bus.sel_b     = 2'd1;
      bus.out_ready = 1'b0;
      step();
      hold_a = bus.op_a;
      step();
      bus.in_valid = 1'b0;
      chk("full2_in_ready", W'(bus.in_ready), '0);
      chk("full2_op_a_hold", bus.op_a, hold_a);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", W'(bus.out_valid), '0);
      chk("async_rst_in_ready", W'(bus.in_ready), W'(1));
      chk("async_rst_op_a", bus.op_a, '0);
      chk("async_rst_op_b", bus.op_b, '0);
      chk("async_rst_sel_err", W'(bus.sel_err), '0);
      step();
      rst_n = 1'b1;
      mq.delete();
      m_err = 1'b0;

      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.sel_a     = 2'($urandom_range(0, 3));
         bus.sel_b     = 2'($urandom_range(0, 3));
         bus.out_ready = ($urandom_range(0, 9) < 6);
         bus.flush     = ($urandom_range(0, 99) < 4);
         bus.src       = {$urandom(), $urandom(), $urandom()};
         tick_model();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
